serial_shifter: RTL and testbench

- Multi-cycle, iterative counterpart of the datapath's single-cycle shifter.
- Shifts one bit per clock under a start/busy/done handshake, so the multi-cycle control FSM can trade shifter area for cycles.
- Reports the last bit shifted out, as ARM operand-2 carry requires.
- Uses the same 3-bit shift-opcode encoding as the combinational shifter; sits between the register-file read latch and the ALU B input.

---
 rtl/serial_shifter.sv | 145 ++++++++++++++
 tb/tb_serial_shifter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_shifter.sv
// serial_shifter: iterative one-bit-per-clock shifter with start/busy/done handshake
// and ARM-style carry-out. Optional N/Z flag outputs under SERIAL_SHIFTER_FLAGS_EN.
module serial_shifter #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [2:0]    shift,
    input  logic [W-1:0]  A,
    input  logic [AW-1:0] B,
    output logic [W-1:0]  out,
    output logic          carry_out,
    output logic          busy,
    output logic          done
`ifdef SERIAL_SHIFTER_FLAGS_EN
    ,
    output logic          n_flag,
    output logic          z_flag
`endif
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    typedef enum logic [2:0] {
        OP_PASS = 3'b000,
        OP_ROL1 = 3'b001,
        OP_ROR1 = 3'b010,
        OP_LSL  = 3'b011,
        OP_ASR  = 3'b100,
        OP_LSR  = 3'b101,
        OP_ROR  = 3'b110,
        OP_RSVD = 3'b111
    } op_t;

    state_t        state, state_d;
    op_t           op, op_d;
    logic [AW-1:0] cnt, cnt_d, n_eff;
    logic [W-1:0]  out_d;
    logic          carry_d, busy_d, done_d;

    always_comb begin
        case (shift)
            OP_LSL, OP_ASR, OP_LSR, OP_ROR: n_eff = B;
            OP_ROL1, OP_ROR1:               n_eff = AW'(1);
            default:                        n_eff = '0;
        endcase
    end

    always_comb begin
        state_d = state;
        op_d    = op;
        cnt_d   = cnt;
        out_d   = out;
        carry_d = carry_out;
        busy_d  = busy;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    op_d    = op_t'(shift);
                    out_d   = A;
                    carry_d = 1'b0;
                    cnt_d   = n_eff;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt != '0) begin
                    cnt_d = cnt - AW'(1);
                    case (op)
                        OP_LSL: begin
                            out_d   = {out[W-2:0], 1'b0};
                            carry_d = out[W-1];
                        end
                        OP_LSR: begin
                            out_d   = {1'b0, out[W-1:1]};
                            carry_d = out[0];
                        end
                        OP_ASR: begin
                            out_d   = {out[W-1], out[W-1:1]};
                            carry_d = out[0];
                        end
                        OP_ROR, OP_ROR1: begin
                            out_d   = {out[0], out[W-1:1]};
                            carry_d = out[0];
                        end
                        OP_ROL1: begin
                            out_d   = {out[W-2:0], out[W-1]};
                            carry_d = out[W-1];
                        end
                        default: begin
                            out_d   = out;
                            carry_d = carry_out;
                        end
                    endcase
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op        <= OP_PASS;
            cnt       <= '0;
            out       <= '0;
            carry_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            op        <= op_d;
            cnt       <= cnt_d;
            out       <= out_d;
            carry_out <= carry_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

`ifdef SERIAL_SHIFTER_FLAGS_EN
    // out is stable on the completion edge, so flags sample the final result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_flag <= 1'b0;
            z_flag <= 1'b0;
        end else if (done_d) begin
            n_flag <= out[W-1];
            z_flag <= (out == '0);
        end
    end
`endif

endmodule

// File: tb/tb_serial_shifter.sv
// Self-checking bench for serial_shifter (W=8, AW=3): directed vector table,
// hand-written corner sequences and randomized ops against an arithmetic model.
module tb_serial_shifter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] shift = 3'b000;
    logic [7:0] A = 8'h00;
    logic [2:0] B = 3'b000;
    logic [7:0] out;
    logic       carry_out, busy, done;
`ifdef SERIAL_SHIFTER_FLAGS_EN
    logic       n_flag, z_flag;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_shifter #(.W(8), .AW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .shift     (shift),
        .A         (A),
        .B         (B),
        .out       (out),
        .carry_out (carry_out),
        .busy      (busy),
        .done      (done)
`ifdef SERIAL_SHIFTER_FLAGS_EN
        ,
        .n_flag    (n_flag),
        .z_flag    (z_flag)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sh;
        logic [7:0] a;
        logic [2:0] b;
        logic [7:0] eo;
        logic       ec;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: whole-word arithmetic on widened operands, carry = last bit to leave.
    function automatic void ref_shift(input logic [2:0] sh, input logic [7:0] a,
                                      input logic [2:0] b, output logic [7:0] o,
                                      output logic c, output int lat);
        int n;
        logic [15:0] t;
        logic signed [15:0] s;
        case (sh)
            3'b011, 3'b100, 3'b101, 3'b110: n = int'(b);
            3'b001, 3'b010:                 n = 1;
            default:                        n = 0;
        endcase
        o = a;
        c = 1'b0;
        case (sh)
            3'b001: begin o = {a[6:0], a[7]}; c = a[7]; end
            3'b010: begin o = {a[0], a[7:1]}; c = a[0]; end
            3'b011: begin t = {8'h00, a} << n; o = t[7:0];  c = (n != 0) && t[8]; end
            3'b100: begin s = $signed({a, 8'h00}) >>> n; o = s[15:8]; c = (n != 0) && s[7]; end
            3'b101: begin t = {a, 8'h00} >> n; o = t[15:8]; c = (n != 0) && t[7]; end
            3'b110: begin t = {a, a} >> n;     o = t[7:0];  c = (n != 0) && o[7]; end
            default: ;
        endcase
        lat = n + 1;
    endfunction

    task automatic start_op(input logic [2:0] sh, input logic [7:0] a, input logic [2:0] b);
        start = 1'b1;
        shift = sh;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = 8'($urandom);
        B     = 3'($urandom);
        shift = 3'($urandom);
    endtask

    // Counts edges after the accepting edge until done; optionally injects noise on inputs.
    task automatic wait_done(input bit noise, output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (lat < 64) begin
            if (busy) bcnt++;
            if (done) break;
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                A     = 8'($urandom);
                B     = 3'($urandom);
                shift = 3'($urandom);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [7:0] eo, input logic ec,
                                input int elat, input int lat, input int bcnt);
        chk({tag, " out"}, 32'(out), 32'(eo));
        chk({tag, " carry"}, 32'(carry_out), 32'(ec));
        chk({tag, " latency"}, 32'(lat), 32'(elat));
        chk({tag, " busy_cycles"}, 32'(bcnt), 32'(elat));
`ifdef SERIAL_SHIFTER_FLAGS_EN
        chk({tag, " n_flag"}, 32'(n_flag), 32'(eo[7]));
        chk({tag, " z_flag"}, 32'(z_flag), 32'(eo == 8'h00));
`endif
    endtask

    task automatic run_check(input string tag, input logic [2:0] sh, input logic [7:0] a,
                             input logic [2:0] b, input logic [7:0] eo, input logic ec,
                             input int elat, input bit noise);
        int lat, bcnt;
        start_op(sh, a, b);
        wait_done(noise, lat, bcnt);
        check_result(tag, eo, ec, elat, lat, bcnt);
    endtask

    initial begin
        int lat, bcnt, elat;
        logic [7:0] eo, held_out;
        logic ec, held_c, saw_done;
        logic [2:0] sh, b;
        logic [7:0] a;

        vecs.push_back('{3'b011, 8'h81, 3'd3, 8'h08, 1'b0, 4});
        vecs.push_back('{3'b100, 8'h90, 3'd5, 8'hFC, 1'b1, 6});
        vecs.push_back('{3'b101, 8'hFF, 3'd7, 8'h01, 1'b1, 8});
        vecs.push_back('{3'b010, 8'h81, 3'd6, 8'hC0, 1'b1, 2});
        vecs.push_back('{3'b110, 8'h01, 3'd3, 8'h20, 1'b0, 4});
        vecs.push_back('{3'b011, 8'h5A, 3'd0, 8'h5A, 1'b0, 1});
        vecs.push_back('{3'b111, 8'h5A, 3'd5, 8'h5A, 1'b0, 1});
        vecs.push_back('{3'b000, 8'hA5, 3'd7, 8'hA5, 1'b0, 1});
        vecs.push_back('{3'b001, 8'h81, 3'd4, 8'h03, 1'b1, 2});
        vecs.push_back('{3'b110, 8'h01, 3'd0, 8'h01, 1'b0, 1});
        vecs.push_back('{3'b100, 8'h7F, 3'd7, 8'h00, 1'b1, 8});
        vecs.push_back('{3'b101, 8'h01, 3'd1, 8'h00, 1'b1, 2});

        repeat (3) @(posedge clk);
        #1;
        chk("reset out", 32'(out), 32'h0);
        chk("reset carry", 32'(carry_out), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset done", 32'(done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i])
            run_check($sformatf("vec%0d", i), vecs[i].sh, vecs[i].a, vecs[i].b,
                      vecs[i].eo, vecs[i].ec, vecs[i].lat, 1'b0);

        // Hold after done, with start low
        held_out = out;
        held_c   = carry_out;
        repeat (3) @(posedge clk);
        #1;
        chk("hold done_low", 32'(done), 32'h0);
        chk("hold out", 32'(out), 32'(held_out));
        chk("hold carry", 32'(carry_out), 32'(held_c));

        // start pulsed mid-operation must be ignored
        start_op(3'b011, 8'h01, 3'd7);
        @(posedge clk);
        #1;
        start = 1'b1; A = 8'hFF; shift = 3'b000; B = 3'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1'b0, lat, bcnt);
        check_result("ignore_start", 8'h80, 1'b0, 8, lat + 2, bcnt + 2);

        // Back-to-back start in the done cycle
        start_op(3'b101, 8'hFF, 3'd2);
        chk("b2b done_drop", 32'(done), 32'h0);
        chk("b2b busy_rise", 32'(busy), 32'h1);
        wait_done(1'b0, lat, bcnt);
        check_result("b2b", 8'h3F, 1'b1, 3, lat, bcnt);

        // Reset during cycle 3 of a 6-step shift
        start_op(3'b011, 8'hFF, 3'd6);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort out", 32'(out), 32'h0);
        chk("abort carry", 32'(carry_out), 32'h0);
        chk("abort busy", 32'(busy), 32'h0);
        chk("abort done", 32'(done), 32'h0);
        saw_done = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        chk("abort no_done", 32'(saw_done), 32'h0);
        chk("abort idle_busy", 32'(busy), 32'h0);

        // Randomized back-to-back ops with input noise while busy
        for (int i = 0; i < 60; i++) begin
            sh = 3'($urandom);
            a  = 8'($urandom);
            b  = 3'($urandom);
            ref_shift(sh, a, b, eo, ec, elat);
            run_check($sformatf("rand%0d op%0b a%0h b%0d", i, sh, a, b), sh, a, b, eo, ec, elat, 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
